program_loader: RTL and testbench

//  Loads a WISC-F18 program into instruction memory. Accepts decoded instruction

---
 rtl/wisc_pkg.sv | 39 +++
 rtl/instr_encoder.sv | 58 +++++
 rtl/program_loader.sv | 126 ++++++++++++
 tb/tb_program_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// wisc_pkg: shared WISC-F18 definitions for the program loader slice.
//   - field widths of the decoded instruction interface
//   - opcode enumeration (ADD..HLT), numbering matches instruction bits [15:12]
//   - loader FSM state enumeration
package wisc_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned IMM_W  = 9;
  localparam int unsigned COND_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE
  } ld_state_e;

endpackage

// File: rtl/instr_encoder.sv
// instr_encoder: combinational WISC-F18 instruction encoder.
//   opcode, rd, rs, rt, imm, cond : decoded instruction fields
//   word    : 16-bit encoded instruction
//   illegal : immediate out of range for the opcode (word is then don't-care)
module instr_encoder
  import wisc_pkg::*;
(
  input  logic [OP_W-1:0]   opcode,
  input  logic [REG_W-1:0]  rd,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [IMM_W-1:0]  imm,
  input  logic [COND_W-1:0] cond,
  output logic [WORD_W-1:0] word,
  output logic              illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (opcode_e'(opcode))
      OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
        word = {opcode, rd, rs, rt};
      end
      OP_SLL, OP_SRA, OP_ROR: begin
        // shift amount 0..15: all upper bits (incl. sign) must be clear
        word    = {opcode, rd, rs, imm[3:0]};
        illegal = (imm[8:4] != '0);
      end
      OP_LW, OP_SW: begin
        // offset -8..7: bits [8:3] must be a pure sign extension
        word    = {opcode, rd, rs, imm[3:0]};
        illegal = !((imm[8:3] == '0) || (imm[8:3] == '1));
      end
      OP_LLB, OP_LHB: begin
        word    = {opcode, rd, imm[7:0]};
        illegal = imm[8];
      end
      OP_B: begin
        word = {opcode, cond, imm};
      end
      OP_BR: begin
        word = {opcode, cond, 1'b0, rs, 4'b0000};
      end
      OP_PCS: begin
        word = {opcode, rd, 8'h00};
      end
      OP_HLT: begin
        word = {opcode, 12'h000};
      end
      default: begin
        word    = '0;
        illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/program_loader.sv
// program_loader: writes a WISC-F18 program into instruction memory.
//   Start/BaseAddr        : begin a load session (sampled only when idle)
//   InValid/InReady       : handshake for decoded instruction fields
//   Opcode..Cond          : decoded fields, encoded by instr_encoder
//   MemWrEn/MemAddr/MemWData/MemReady : imem write port, held until MemReady
//   Done  : one-cycle pulse at end of load (HLT written or address overflow)
//   Err   : sticky per session, illegal immediate or address overflow
//   Count : words written since Start
module program_loader
  import wisc_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Start,
  input  logic [ADDR_W-1:0]   BaseAddr,
  input  logic                InValid,
  output logic                InReady,
  input  logic [OP_W-1:0]     Opcode,
  input  logic [REG_W-1:0]    Rd,
  input  logic [REG_W-1:0]    Rs,
  input  logic [REG_W-1:0]    Rt,
  input  logic [IMM_W-1:0]    Imm,
  input  logic [COND_W-1:0]   Cond,
  output logic                MemWrEn,
  output logic [ADDR_W-1:0]   MemAddr,
  output logic [WORD_W-1:0]   MemWData,
  input  logic                MemReady,
  output logic                Done,
  output logic                Err,
  output logic [ADDR_W-1:0]   Count
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = {{(ADDR_W-1){1'b1}}, 1'b0};

  ld_state_e           state, state_nxt;
  logic [WORD_W-1:0]   enc_word;
  logic                enc_illegal;
  logic                word_is_hlt;
  logic                addr_at_max;

  instr_encoder u_enc (
    .opcode  (Opcode),
    .rd      (Rd),
    .rs      (Rs),
    .rt      (Rt),
    .imm     (Imm),
    .cond    (Cond),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign word_is_hlt = (opcode_e'(MemWData[15:12]) == OP_HLT);
  assign addr_at_max = (MemAddr == ADDR_MAX);

  // Handshake strobes decode straight from the state so an async reset
  // drops them immediately.
  always_comb begin
    state_nxt = state;
    InReady   = 1'b0;
    MemWrEn   = 1'b0;
    Done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        InReady = 1'b1;
        if (InValid && !enc_illegal) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        MemWrEn = 1'b1;
        if (MemReady) state_nxt = (word_is_hlt || addr_at_max) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        Done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MemAddr  <= '0;
      MemWData <= '0;
      Count    <= '0;
      Err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            MemAddr <= {BaseAddr[ADDR_W-1:1], 1'b0};
            Count   <= '0;
            Err     <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (InValid) begin
            if (enc_illegal) Err <= 1'b1;
            else             MemWData <= enc_word;
          end
        end
        ST_WRITE: begin
          if (MemReady) begin
            Count <= Count + ADDR_W'(1);
            // HLT ends the load cleanly even at the top address; only a
            // non-HLT word there is an overflow, and the address never wraps.
            if (!word_is_hlt) begin
              if (addr_at_max) Err <= 1'b1;
              else             MemAddr <= MemAddr + ADDR_W'(2);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit address instance
  logic        rst_n, start, in_valid, in_ready, mem_wr_en, mem_ready, done, err;
  logic [15:0] base, mem_addr, mem_wdata, count;
  logic [3:0]  opcode, rd, rs, rt;
  logic [8:0]  imm;
  logic [2:0]  cond;

  program_loader #(.ADDR_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .Start(start), .BaseAddr(base),
    .InValid(in_valid), .InReady(in_ready), .Opcode(opcode), .Rd(rd), .Rs(rs),
    .Rt(rt), .Imm(imm), .Cond(cond), .MemWrEn(mem_wr_en), .MemAddr(mem_addr),
    .MemWData(mem_wdata), .MemReady(mem_ready), .Done(done), .Err(err),
    .Count(count)
  );

  // 4-bit address instance for overflow / async reset checks
  logic        rst4_n, start4, valid4, ready4, wr4, mready4, done4, err4;
  logic [3:0]  base4, addr4, count4;
  logic [15:0] wdata4;

  program_loader #(.ADDR_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .Start(start4), .BaseAddr(base4),
    .InValid(valid4), .InReady(ready4), .Opcode(4'h0), .Rd(4'h1), .Rs(4'h2),
    .Rt(4'h3), .Imm(9'h000), .Cond(3'h0), .MemWrEn(wr4), .MemAddr(addr4),
    .MemWData(wdata4), .MemReady(mready4), .Done(done4), .Err(err4),
    .Count(count4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding computed from the instruction-format table with
  // integer arithmetic and a signed view of the immediate.
  function automatic void ref_encode(input int op, input int frd, input int frs,
                                     input int frt, input int imm9, input int cnd,
                                     output int word, output bit ok);
    int simm;
    simm = (imm9 >= 256) ? imm9 - 512 : imm9;
    ok   = 1'b1;
    word = op * 4096;
    if (op <= 3 || op == 7) begin
      word += frd * 256 + frs * 16 + frt;
    end else if (op <= 6) begin
      ok = (simm >= 0) && (simm <= 15);
      word += frd * 256 + frs * 16 + (simm & 15);
    end else if (op <= 9) begin
      ok = (simm >= -8) && (simm <= 7);
      word += frd * 256 + frs * 16 + (simm & 15);
    end else if (op <= 11) begin
      ok = (simm >= 0);
      word += frd * 256 + (imm9 & 255);
    end else if (op == 12) begin
      word += cnd * 512 + imm9;
    end else if (op == 13) begin
      word += cnd * 512 + frs * 16;
    end else if (op == 14) begin
      word += frd * 256;
    end
  endfunction

  // Behavioural model of the 16-bit instance: session activity, pending
  // write, done pulse, address, count and error flag.
  bit m_active, m_pend, m_done, m_err;
  int m_addr, m_count, m_word;

  always @(negedge clk) begin
    int w;
    bit ok;
    if (!rst_n) begin
      m_active = 0; m_pend = 0; m_done = 0; m_err = 0;
      m_addr = 0; m_count = 0; m_word = 0;
    end else begin
      check("in_ready", in_ready, m_active && !m_pend && !m_done);
      check("mem_wr_en", mem_wr_en, m_pend);
      check("done", done, m_done);
      check("mem_addr", mem_addr, m_addr);
      check("count", count, m_count);
      check("err", err, m_err);
      if (m_pend) check("mem_wdata", mem_wdata, m_word);
      if (m_done) begin
        m_done = 0;
        m_active = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1; m_addr = base & 16'hFFFE; m_count = 0; m_err = 0;
        end
      end else if (m_pend) begin
        if (mem_ready) begin
          m_count = (m_count + 1) & 16'hFFFF;
          m_pend  = 0;
          if ((m_word >> 12) == 15) m_done = 1;
          else if (m_addr == 16'hFFFE) begin m_err = 1; m_done = 1; end
          else m_addr += 2;
        end
      end else if (in_valid) begin
        ref_encode(opcode, rd, rs, rt, imm, cond, w, ok);
        if (ok) begin m_pend = 1; m_word = w; end
        else m_err = 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] frd, input logic [3:0] frs,
                      input logic [3:0] frt, input logic [8:0] fimm, input logic [2:0] fcond);
    opcode = op; rd = frd; rs = frs; rt = frt; imm = fimm; cond = fcond;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic accept;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  initial begin
    int w;
    bit ok;

    // Pin the reference encoder with hand-computed words.
    ref_encode(0, 1, 2, 3, 0, 0, w, ok);        check("model_add", w, 32'h0123);
    ref_encode(10, 4, 0, 0, 'h05A, 0, w, ok);   check("model_llb", w, 32'hA45A);
    ref_encode(8, 5, 6, 0, 'h1FE, 0, w, ok);    check("model_lw", w, 32'h856E);
    ref_encode(12, 0, 0, 0, 'h1FF, 3, w, ok);   check("model_b", w, 32'hC7FF);
    ref_encode(4, 0, 0, 0, 16, 0, w, ok);       check("model_sll16_ok", ok, 0);
    ref_encode(10, 0, 0, 0, 'h15A, 0, w, ok);   check("model_llb_neg_ok", ok, 0);

    rst_n = 0; rst4_n = 0;
    start = 0; base = '0; in_valid = 0; mem_ready = 0;
    opcode = '0; rd = '0; rs = '0; rt = '0; imm = '0; cond = '0;
    start4 = 0; base4 = '0; valid4 = 0; mready4 = 0;
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_count", count, 0);
    rst_n = 1; rst4_n = 1;
    tick();

    // ADD at base 0 with MemReady held off for 3 cycles
    base = 16'h0000; start = 1; tick(); start = 0;
    send(4'h0, 4'h1, 4'h2, 4'h3, 9'h000, 3'h0);
    for (int i = 0; i < 3; i++) begin
      check("stall_wr_en", mem_wr_en, 1);
      check("stall_addr", mem_addr, 16'h0000);
      check("stall_wdata", mem_wdata, 16'h0123);
      check("stall_in_ready", in_ready, 0);
      tick();
    end
    accept();
    check("add_count", count, 1);

    send(4'hA, 4'h4, 4'h0, 4'h0, 9'h05A, 3'h0);
    check("llb_addr", mem_addr, 16'h0002);
    check("llb_wdata", mem_wdata, 16'hA45A);
    accept();
    send(4'h8, 4'h5, 4'h6, 4'h0, 9'h1FE, 3'h0);
    check("lw_addr", mem_addr, 16'h0004);
    check("lw_wdata", mem_wdata, 16'h856E);
    accept();
    check("lw_count", count, 3);

    // illegal shift amount: error, no write, address unchanged
    send(4'h4, 4'h1, 4'h1, 4'h0, 9'd16, 3'h0);
    check("sll16_err", err, 1);
    check("sll16_wr_en", mem_wr_en, 0);
    check("sll16_in_ready", in_ready, 1);
    send(4'h0, 4'h1, 4'h2, 4'h3, 9'h000, 3'h0);
    check("after_err_addr", mem_addr, 16'h0006);
    check("after_err_wdata", mem_wdata, 16'h0123);
    accept();
    send(4'hF, 4'h0, 4'h0, 4'h0, 9'h000, 3'h0);
    accept();
    tick();

    // fresh session: branch then HLT, error clears on Start
    base = 16'h0101; start = 1; tick(); start = 0;
    check("sess2_err", err, 0);
    send(4'hC, 4'h0, 4'h0, 4'h0, 9'h1FF, 3'h3);
    check("b_addr", mem_addr, 16'h0100);
    check("b_wdata", mem_wdata, 16'hC7FF);
    accept();
    send(4'hF, 4'h7, 4'h7, 4'h7, 9'h1AB, 3'h5);
    check("hlt_addr", mem_addr, 16'h0102);
    check("hlt_wdata", mem_wdata, 16'hF000);
    accept();
    check("hlt_done", done, 1);
    check("hlt_err", err, 0);
    check("hlt_count", count, 2);
    tick();
    check("hlt_done_clear", done, 0);
    check("idle_in_ready", in_ready, 0);
    check("idle_addr_hold", mem_addr, 16'h0102);

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      start     = ($urandom_range(0, 7) == 0);
      base      = ($urandom_range(0, 2) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                              : 16'($urandom);
      in_valid  = ($urandom_range(0, 9) < 7);
      mem_ready = ($urandom_range(0, 9) < 6);
      opcode    = 4'($urandom);
      rd        = 4'($urandom);
      rs        = 4'($urandom);
      rt        = 4'($urandom);
      cond      = 3'($urandom);
      imm       = ($urandom_range(0, 1) == 0) ? 9'($urandom) : 9'($urandom_range(0, 25) - 9);
      tick();
    end
    start = 0; in_valid = 0; mem_ready = 0;
    tick();

    // 4-bit address: non-HLT word at the top address overflows
    base4 = 4'hE; start4 = 1; tick(); start4 = 0;
    valid4 = 1; tick(); valid4 = 0;
    check("ovf_wr_en", wr4, 1);
    check("ovf_addr", addr4, 4'hE);
    check("ovf_wdata", wdata4, 16'h0123);
    mready4 = 1; tick(); mready4 = 0;
    check("ovf_done", done4, 1);
    check("ovf_err", err4, 1);
    check("ovf_count", count4, 1);
    check("ovf_addr_nowrap", addr4, 4'hE);
    tick();
    check("ovf_done_clear", done4, 0);
    check("ovf_err_hold", err4, 1);

    // async reset while a write is pending
    base4 = 4'h3; start4 = 1; tick(); start4 = 0;
    valid4 = 1; tick(); valid4 = 0;
    check("w4_wr_en", wr4, 1);
    check("w4_addr_bit0", addr4, 4'h2);
    #2 rst4_n = 0;
    #1;
    check("arst_wr_en", wr4, 0);
    check("arst_addr", addr4, 0);
    check("arst_err", err4, 0);
    check("arst_ready", ready4, 0);
    rst4_n = 1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
